// File: rtl/ibuffer_issue_arb.sv
// ibuffer_issue_arb: reader side of the per-warp instruction buffers.
// Picks one eligible warp per cycle, round-robin from the warp after the
// last one issued. The winner is forwarded through one registered output
// stage together with its warp index.
// Optional stall performance counter: define IBUF_ARB_PERF_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. On the ibuffer side ibuf_ready[w] is the pop, and it is
// asserted only for the granted warp. On the output side out_valid, once
// high, holds out_data/out_wid stable until out_ready accepts them.
module ibuffer_issue_arb #(
    parameter int NUM_WARPS  = 4,
    parameter int DATAW      = 64,
    parameter int WIDW       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int PERF_CTR_W = 44
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_WARPS-1:0]       ibuf_valid,
    input  logic [NUM_WARPS*DATAW-1:0] ibuf_data,
    output logic [NUM_WARPS-1:0]       ibuf_ready,
    input  logic [NUM_WARPS-1:0]       warp_stall,
    output logic                       out_valid,
    output logic [DATAW-1:0]           out_data,
    output logic [WIDW-1:0]            out_wid,
    input  logic                       out_ready
`ifdef IBUF_ARB_PERF_EN
    ,
    output logic [PERF_CTR_W-1:0]      perf_stalls
`endif
);

    logic [NUM_WARPS-1:0] elig;
    logic [NUM_WARPS-1:0] grant;
    logic [WIDW-1:0]      grant_idx;
    logic [WIDW-1:0]      scan_idx;
    logic                 found;
    logic                 load;
    logic                 pop;
    logic [WIDW-1:0]      rr_ptr;
    logic [DATAW-1:0]     sel_data;

    assign elig = ibuf_valid & ~warp_stall;

    // Round-robin scan starting one past the last issued warp, wrapping.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        scan_idx  = '0;
        found     = 1'b0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            scan_idx = WIDW'((int'(rr_ptr) + i) % NUM_WARPS);
            if (!found && elig[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
            end
        end
    end

    // The output stage may load when empty or when its content is accepted.
    assign load       = ~out_valid | out_ready;
    assign pop        = load & found;
    assign ibuf_ready = load ? grant : '0;
    assign sel_data   = ibuf_data[int'(grant_idx)*DATAW +: DATAW];

    // Output register: valid follows the grant; payload/index only on a pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_wid   <= '0;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_data <= sel_data;
                out_wid  <= grant_idx;
            end
        end
    end

    // Rotation pointer moves only when an instruction actually leaves the ibuffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= WIDW'(NUM_WARPS - 1);
        end else if (pop) begin
            rr_ptr <= grant_idx;
        end
    end

`ifdef IBUF_ARB_PERF_EN
    // Count cycles where some warp has an instruction but none is popped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stalls <= '0;
        end else if ((|ibuf_valid) && !pop) begin
            perf_stalls <= perf_stalls + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    // At most one ibuffer is popped per cycle.
    a_ready_onehot0 : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(ibuf_ready));

    // A held output does not change until it is accepted.
    a_out_stable : assert property (@(posedge clk) disable iff (!reset)
        (out_valid && !out_ready) |=>
            ($stable(out_valid) && $stable(out_data) && $stable(out_wid)));
`endif

endmodule

// File: tb/tb_ibuffer_issue_arb.sv
// Testbench for ibuffer_issue_arb (NUM_WARPS=4, DATAW=64): directed vector
// table, hand-written reset/perf sequences, and random traffic checked
// against a queue-level issue model.
module tb_ibuffer_issue_arb;

    localparam int NW = 4;
    localparam int DW = 64;
    localparam int WW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NW-1:0]    ibuf_valid;
    logic [NW*DW-1:0] ibuf_data;
    logic [NW-1:0]    ibuf_ready;
    logic [NW-1:0]    warp_stall;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic [WW-1:0]    out_wid;
    logic             out_ready;
`ifdef IBUF_ARB_PERF_EN
    logic [43:0]      perf_stalls;
`endif

    ibuffer_issue_arb #(.NUM_WARPS(NW), .DATAW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ibuf_valid (ibuf_valid),
        .ibuf_data  (ibuf_data),
        .ibuf_ready (ibuf_ready),
        .warp_stall (warp_stall),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_wid    (out_wid),
        .out_ready  (out_ready)
`ifdef IBUF_ARB_PERF_EN
        ,
        .perf_stalls(perf_stalls)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] payload [NW];

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pack_payload();
        for (int w = 0; w < NW; w++) ibuf_data[w*DW +: DW] = payload[w];
    endtask

    task automatic apply(input logic [NW-1:0] v, input logic [NW-1:0] s, input logic r);
        ibuf_valid = v;
        warp_stall = s;
        out_ready  = r;
        pack_payload();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- behavioural issue model ----------------
    // The model keeps "last issued warp" and the contents of the output slot.
    int            m_last;
    logic          m_ov;
    logic [DW-1:0] m_data;
    int            m_wid;
    int            m_pick;
    logic          m_load;

    task automatic model_reset();
        m_last = NW - 1;
        m_ov   = 1'b0;
        m_data = '0;
        m_wid  = 0;
    endtask

    function automatic logic [NW-1:0] model_ready();
        m_load = !m_ov || out_ready;
        m_pick = -1;
        for (int k = 1; k <= NW; k++) begin
            int w;
            w = (m_last + k) % NW;
            if (m_pick < 0 && ibuf_valid[w] && !warp_stall[w]) m_pick = w;
        end
        if (m_load && m_pick >= 0) return NW'(1) << m_pick;
        return '0;
    endfunction

    task automatic model_edge();
        if (m_load) begin
            m_ov = (m_pick >= 0);
            if (m_pick >= 0) begin
                m_data = payload[m_pick];
                m_wid  = m_pick;
                m_last = m_pick;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NW-1:0] v;
        logic [NW-1:0] s;
        logic          r;
        logic [NW-1:0] exp_ready;
        logic          exp_ov;
        logic [WW-1:0] exp_wid;
    } vec_t;

    vec_t tab [18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // full rotation
        tab[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0};
        tab[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1};
        tab[2]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2};
        tab[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3};
        tab[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0};
        tab[5]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1};
        tab[6]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2};
        tab[7]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3};
        // stalled warp 1 skipped, then granted before warp 3
        tab[8]  = '{4'b1010, 4'b0010, 1'b1, 4'b1000, 1'b1, 2'd3};
        tab[9]  = '{4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1};
        // warp 2 issued, then 3 backpressured cycles, then warp 3
        tab[10] = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2};
        tab[11] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
        tab[12] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
        tab[13] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
        tab[14] = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3};
        // idle gap: valid drops, index/data hold, rotation continues
        tab[15] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};
        tab[16] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};
        tab[17] = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0};

        for (int w = 0; w < NW; w++) payload[w] = {8'(w + 1), 24'hC0FFEE, 32'(32'h1000 * (w + 3))};
        apply('0, '0, 1'b1);
        do_reset();

        // reset state
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_wid", 64'(out_wid), 64'd0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            apply(tab[i].v, tab[i].s, tab[i].r);
            #1;
            check($sformatf("vec%0d_ibuf_ready", i), 64'(ibuf_ready), 64'(tab[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tab[i].exp_ov));
            check($sformatf("vec%0d_out_wid", i), 64'(out_wid), 64'(tab[i].exp_wid));
            check($sformatf("vec%0d_out_data", i), out_data, payload[tab[i].exp_wid]);
        end

        // asynchronous reset while the output slot is full
        @(negedge clk);
        apply(4'b1111, 4'b0000, 1'b1);
        @(posedge clk);
        #1;
        check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        check("pre_reset_out_wid", 64'(out_wid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'd0);
        check("async_reset_out_wid", 64'(out_wid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_reset_first_grant", 64'(ibuf_ready), 64'b0001);
        @(posedge clk);
        #1;
        check("post_reset_out_wid", 64'(out_wid), 64'd0);
        check("post_reset_out_data", out_data, payload[0]);

`ifdef IBUF_ARB_PERF_EN
        // 5 all-stalled cycles, one pop, 2 backpressured cycles
        @(negedge clk);
        apply('0, '0, 1'b1);
        do_reset();
        apply(4'b1111, 4'b1111, 1'b1);
        repeat (5) @(negedge clk);
        apply(4'b1111, 4'b0000, 1'b1);
        @(negedge clk);
        apply(4'b1111, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        apply(4'b0000, 4'b0000, 1'b1);
        check("perf_stalls", 64'(perf_stalls), 64'd7);
`endif

        // random traffic against the model
        @(negedge clk);
        apply('0, '0, 1'b1);
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            logic [NW-1:0] exp_rdy;
            @(negedge clk);
            if (!(out_valid && !out_ready)) begin
                for (int w = 0; w < NW; w++) payload[w] = {$urandom, $urandom};
            end
            apply(NW'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? NW'($urandom_range(0, 15)) : '0,
                  ($urandom_range(0, 3) != 0));
            #1;
            exp_rdy = model_ready();
            check("rand_ibuf_ready", 64'(ibuf_ready), 64'(exp_rdy));
            @(posedge clk);
            model_edge();
            #1;
            check("rand_out_valid", 64'(out_valid), 64'(m_ov));
            check("rand_out_wid", 64'(out_wid), 64'(m_wid));
            check("rand_out_data", out_data, m_data);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
